// File: rtl/x_usr_access_arbiter.sv
// x_usr_access_arbiter
// Shares one USR_ACCESS configuration-word source (DATA/DATAVALID) among NUM_REQ
// requesters. Arbitration is round-robin, and each grant covers one read transaction.
// A grant ends in one of three ways:
//   - a live DATAVALID word is returned,
//   - a timeout error is returned,
//   - the grant is dropped because the requester released REQ.
// Optional feature macro: X_USR_ACCESS_CACHE_EN. It keeps the last word seen with
// DATAVALID so that a grant can be answered without waiting for a fresh DATAVALID.
module x_usr_access_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        DATA,
  input  logic               DATAVALID,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic [31:0]        RDATA,
  output logic               RVALID,
  output logic               RERR,
  output logic               BUSY
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CW   = IDXW + 1;
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);
  localparam logic [CW-1:0]   NUM_REQ_C = CW'(NUM_REQ);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } stateT;

  stateT              state;
  stateT              stateNext;
  logic [NUM_REQ-1:0] gntNext;
  logic [IDXW-1:0]    gntIdx;
  logic [IDXW-1:0]    gntIdxNext;
  logic [IDXW-1:0]    rrPtr;
  logic [IDXW-1:0]    rrNext;
  logic [IDXW-1:0]    ownerPlusOne;
  logic [IDXW-1:0]    pickIdx;
  logic               pickFound;
  logic [CW-1:0]      cand;
  logic [IDXW-1:0]    candIdx;
  logic [CNTW-1:0]    cnt;
  logic [CNTW-1:0]    cntNext;
  logic [31:0]        rdataNext;
  logic               rvalidNext;
  logic               rerrNext;
  logic               ownerReq;
  logic               cacheHit;
  logic [31:0]        cacheWord;

`ifdef X_USR_ACCESS_CACHE_EN
  logic [31:0] cacheData;
  logic        cacheValid;

  // Capture every valid USR_ACCESS word, regardless of arbiter state
  always_ff @(posedge CLK) begin
    if (RST) begin
      cacheData  <= '0;
      cacheValid <= 1'b0;
    end else if (DATAVALID) begin
      cacheData  <= DATA;
      cacheValid <= 1'b1;
    end
  end

  assign cacheHit  = cacheValid;
  assign cacheWord = cacheData;
`else
  assign cacheHit  = 1'b0;
  assign cacheWord = '0;
`endif

  assign BUSY         = (state != ST_IDLE);
  assign ownerReq     = |(REQ & GNT);
  assign ownerPlusOne = (gntIdx == LAST_IDX) ? '0 : gntIdx + 1'b1;

  // Round-robin pick: first requesting index at or above rrPtr, wrapping around
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    candIdx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rrPtr} + CW'(i);
      if (cand >= NUM_REQ_C) begin
        cand = cand - NUM_REQ_C;
      end
      candIdx = cand[IDXW-1:0];
      if (!pickFound && REQ[candIdx]) begin
        pickFound = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  // Transaction sequencing: grant, wait for a word or a timeout, respond for one cycle
  always_comb begin
    stateNext  = state;
    gntNext    = GNT;
    gntIdxNext = gntIdx;
    rrNext     = rrPtr;
    cntNext    = cnt;
    rdataNext  = RDATA;
    rvalidNext = 1'b0;
    rerrNext   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pickFound) begin
          gntNext          = '0;
          gntNext[pickIdx] = 1'b1;
          gntIdxNext       = pickIdx;
          cntNext          = '0;
          stateNext        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!ownerReq) begin
          gntNext   = '0;
          rrNext    = ownerPlusOne;
          stateNext = ST_IDLE;
        end else if (DATAVALID) begin
          rdataNext  = DATA;
          rvalidNext = 1'b1;
          stateNext  = ST_RESP;
        end else if (cacheHit) begin
          rdataNext  = cacheWord;
          rvalidNext = 1'b1;
          stateNext  = ST_RESP;
        end else if (cnt == CNT_LAST) begin
          rdataNext  = '0;
          rvalidNext = 1'b1;
          rerrNext   = 1'b1;
          stateNext  = ST_RESP;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      ST_RESP: begin
        gntNext   = '0;
        rrNext    = ownerPlusOne;
        stateNext = ST_IDLE;
      end
      default: begin
        gntNext   = '0;
        stateNext = ST_IDLE;
      end
    endcase
  end

  // State, grant and response registers; reset drops any in-flight transaction
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      GNT    <= '0;
      gntIdx <= '0;
      rrPtr  <= '0;
      cnt    <= '0;
      RDATA  <= '0;
      RVALID <= 1'b0;
      RERR   <= 1'b0;
    end else begin
      state  <= stateNext;
      GNT    <= gntNext;
      gntIdx <= gntIdxNext;
      rrPtr  <= rrNext;
      cnt    <= cntNext;
      RDATA  <= rdataNext;
      RVALID <= rvalidNext;
      RERR   <= rerrNext;
    end
  end

endmodule

// File: tb/tb_x_usr_access_arbiter.sv
// tb_x_usr_access_arbiter
// Directed scenarios plus randomized traffic, checked against a transaction-level
// reference model. Honours X_USR_ACCESS_CACHE_EN in the same way as the design.
module tb_x_usr_access_arbiter;

  localparam int NREQ = 4;
  localparam int TOUT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     data;
  logic            dataValid;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [31:0]     rdata;
  logic            rvalid;
  logic            rerr;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 when nobody holds a grant) plus expected outputs
  int              mOwner = -1;
  int              mWaited = 0;
  int              mRr = 0;
  bit              mInResp = 1'b0;
  bit              mCacheValid = 1'b0;
  logic [31:0]     mCache = '0;
  logic [NREQ-1:0] eGnt = '0;
  logic            eRvalid = 1'b0;
  logic            eRerr = 1'b0;
  logic            eBusy = 1'b0;
  logic [31:0]     eRdata = '0;

  x_usr_access_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TOUT)) dut (
    .CLK(clk), .RST(rst), .DATA(data), .DATAVALID(dataValid), .REQ(req),
    .GNT(gnt), .RDATA(rdata), .RVALID(rvalid), .RERR(rerr), .BUSY(busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the test sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  // Advance the model by one clock edge using the inputs the DUT is seeing
  function automatic void modelStep();
    bit found;
    int cand;
    found = 1'b0;
    if (rst) begin
      mOwner      = -1;
      mInResp     = 1'b0;
      mWaited     = 0;
      mRr         = 0;
      mCacheValid = 1'b0;
      mCache      = '0;
      eRvalid     = 1'b0;
      eRerr       = 1'b0;
      eRdata      = '0;
    end else begin
      eRvalid = 1'b0;
      eRerr   = 1'b0;
      if (mOwner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          cand = (mRr + k) % NREQ;
          if (!found && req[cand]) begin
            found   = 1'b1;
            mOwner  = cand;
            mWaited = 0;
          end
        end
      end else if (mInResp) begin
        mRr     = (mOwner + 1) % NREQ;
        mOwner  = -1;
        mInResp = 1'b0;
      end else if (!req[mOwner]) begin
        mRr    = (mOwner + 1) % NREQ;
        mOwner = -1;
      end else if (dataValid) begin
        eRdata  = data;
        eRvalid = 1'b1;
        mInResp = 1'b1;
`ifdef X_USR_ACCESS_CACHE_EN
      end else if (mCacheValid) begin
        eRdata  = mCache;
        eRvalid = 1'b1;
        mInResp = 1'b1;
`endif
      end else if (mWaited + 1 >= TOUT) begin
        eRdata  = '0;
        eRvalid = 1'b1;
        eRerr   = 1'b1;
        mInResp = 1'b1;
      end else begin
        mWaited++;
      end
`ifdef X_USR_ACCESS_CACHE_EN
      if (dataValid) begin
        mCache      = data;
        mCacheValid = 1'b1;
      end
`endif
    end
    eGnt = '0;
    if (mOwner >= 0) eGnt[mOwner] = 1'b1;
    eBusy = (mOwner >= 0);
  endfunction

  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq,
                               input logic dv, input logic [31:0] d);
    rst       = r;
    req       = rq;
    dataValid = dv;
    data      = d;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 4'hF, 1'b1, 32'h5555_AAAA);
    tick();
    tick();
    checks++;
    if ({gnt, rvalid, rerr, busy} !== 7'b0000_000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got gnt=%b rvalid=%b rerr=%b busy=%b want all zero", gnt, rvalid, rerr, busy);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata got %h want 00000000", rdata);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if ({gnt, rvalid, rerr, busy} !== 7'b0000_000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got gnt=%b rvalid=%b busy=%b want zero", gnt, rvalid, busy);
    end
  endtask

  task automatic test_timeout();
    applyStimulus(1'b0, 4'b0001, 1'b0, 32'hDEAD_BEEF);
    tick();
    checks++;
    if ({gnt, rvalid, rerr, busy} !== {4'b0001, 3'b001}) begin
      errors++;
      $display("[TB] FAIL timeout_grant got gnt=%b rvalid=%b busy=%b want 0001/0/1", gnt, rvalid, busy);
    end
    for (int k = 0; k < TOUT - 1; k++) begin
      tick();
      checks++;
      if (rvalid !== 1'b0 || gnt !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL timeout_wait%0d got gnt=%b rvalid=%b want 0001/0", k, gnt, rvalid);
      end
    end
    tick();
    checks++;
    if ({gnt, rvalid, rerr, busy} !== {4'b0001, 3'b111}) begin
      errors++;
      $display("[TB] FAIL timeout_resp got gnt=%b rvalid=%b rerr=%b busy=%b want 0001/1/1/1", gnt, rvalid, rerr, busy);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL timeout_rdata got %h want 00000000", rdata);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if ({gnt, rvalid, rerr, busy} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL timeout_release got gnt=%b rvalid=%b rerr=%b busy=%b want zero", gnt, rvalid, rerr, busy);
    end
  endtask

  task automatic test_single_read();
    applyStimulus(1'b0, 4'b0100, 1'b1, 32'hCAFE_0001);
    tick();
    checks++;
    if ({gnt, rvalid, rerr, busy} !== {4'b0100, 3'b001}) begin
      errors++;
      $display("[TB] FAIL single_grant got gnt=%b rvalid=%b busy=%b want 0100/0/1", gnt, rvalid, busy);
    end
    tick();
    checks++;
    if ({gnt, rvalid, rerr, busy} !== {4'b0100, 3'b101}) begin
      errors++;
      $display("[TB] FAIL single_resp got gnt=%b rvalid=%b rerr=%b want 0100/1/0", gnt, rvalid, rerr);
    end
    checks++;
    if (rdata !== 32'hCAFE_0001) begin
      errors++;
      $display("[TB] FAIL single_rdata got %h want cafe0001", rdata);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if ({gnt, rvalid, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL single_release got gnt=%b rvalid=%b busy=%b want zero", gnt, rvalid, busy);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] eg;
    logic [31:0]     word;
    applyStimulus(1'b1, 4'h0, 1'b0, 32'h0);
    tick();
    for (int t = 0; t < 5; t++) begin
      eg = '0;
      eg[t % NREQ] = 1'b1;
      word = 32'hF000_0000 | t;
      applyStimulus(1'b0, 4'hF, 1'b1, word);
      tick();
      checks++;
      if (gnt !== eg || rvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fair_grant%0d got gnt=%b rvalid=%b want %b/0", t, gnt, rvalid, eg);
      end
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== word || rerr !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fair_resp%0d got rvalid=%b rdata=%h rerr=%b want 1/%h/0", t, rvalid, rdata, rerr, word);
      end
      tick();
      checks++;
      if (rvalid !== 1'b0 || gnt !== 4'b0) begin
        errors++;
        $display("[TB] FAIL fair_pulse%0d got rvalid=%b gnt=%b want 0/0000", t, rvalid, gnt);
      end
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_abort();
    applyStimulus(1'b1, 4'h0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 4'b0010, 1'b0, 32'h0);
    tick();
    tick();
    checks++;
    if ({gnt, rvalid, busy} !== {4'b0010, 2'b01}) begin
      errors++;
      $display("[TB] FAIL abort_wait got gnt=%b rvalid=%b busy=%b want 0010/0/1", gnt, rvalid, busy);
    end
    applyStimulus(1'b0, 4'b1101, 1'b1, 32'h1111_2222);
    tick();
    checks++;
    if ({gnt, rvalid, rerr, busy} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL abort_drop got gnt=%b rvalid=%b rerr=%b busy=%b want zero", gnt, rvalid, rerr, busy);
    end
    applyStimulus(1'b0, 4'b1101, 1'b0, 32'h0);
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL abort_next_grant got %b want 0100", gnt);
    end
    applyStimulus(1'b0, 4'b1101, 1'b1, 32'h0BAD_F00D);
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("[TB] FAIL abort_resp got rvalid=%b rdata=%h want 1/0badf00d", rvalid, rdata);
    end
    applyStimulus(1'b1, 4'b1101, 1'b1, 32'h0BAD_F00D);
    tick();
    checks++;
    if ({gnt, rvalid, rerr, busy} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_resp got gnt=%b rvalid=%b rerr=%b busy=%b want zero", gnt, rvalid, rerr, busy);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 32'h0);
    tick();
  endtask

`ifdef X_USR_ACCESS_CACHE_EN
  task automatic test_cache();
    applyStimulus(1'b1, 4'h0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b1, 32'h1234_5678);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b0, 32'hFFFF_0000);
    tick();
    applyStimulus(1'b0, 4'b1000, 1'b0, 32'hFFFF_0000);
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL cache_grant got %b want 1000", gnt);
    end
    tick();
    checks++;
    if (rvalid !== 1'b1 || rerr !== 1'b0 || rdata !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL cache_resp got rvalid=%b rerr=%b rdata=%h want 1/0/12345678", rvalid, rerr, rdata);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 4'b0001, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 4'b0001, 1'b1, 32'hAAAA_5555);
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hAAAA_5555) begin
      errors++;
      $display("[TB] FAIL cache_live_priority got rvalid=%b rdata=%h want 1/aaaa5555", rvalid, rdata);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 32'h0);
    tick();
  endtask
`else
  task automatic test_no_cache();
    applyStimulus(1'b1, 4'h0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b1, 32'h1234_5678);
    tick();
    applyStimulus(1'b0, 4'b1000, 1'b0, 32'hFFFF_0000);
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL nocache_grant got %b want 1000", gnt);
    end
    for (int k = 0; k < TOUT - 1; k++) begin
      tick();
      checks++;
      if (rvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL nocache_wait%0d got rvalid=%b want 0", k, rvalid);
      end
    end
    tick();
    checks++;
    if (rvalid !== 1'b1 || rerr !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL nocache_timeout got rvalid=%b rerr=%b rdata=%h want 1/1/00000000", rvalid, rerr, rdata);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 32'h0);
    tick();
  endtask
`endif

  task automatic test_random();
    logic [NREQ-1:0] rq;
    applyStimulus(1'b1, 4'h0, 1'b0, 32'h0);
    tick();
    rq = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rq = NREQ'($urandom);
      applyStimulus(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 4) == 0), $urandom);
      tick();
      checks++;
      if (gnt !== eGnt) begin
        errors++;
        $display("[TB] FAIL rand_gnt cycle %0d got %b want %b", c, gnt, eGnt);
      end
      checks++;
      if (rvalid !== eRvalid || rerr !== eRerr) begin
        errors++;
        $display("[TB] FAIL rand_resp cycle %0d got rvalid=%b rerr=%b want %b/%b", c, rvalid, rerr, eRvalid, eRerr);
      end
      checks++;
      if (busy !== eBusy) begin
        errors++;
        $display("[TB] FAIL rand_busy cycle %0d got %b want %b", c, busy, eBusy);
      end
      if (eRvalid) begin
        checks++;
        if (rdata !== eRdata) begin
          errors++;
          $display("[TB] FAIL rand_rdata cycle %0d got %h want %h", c, rdata, eRdata);
        end
      end
    end
  endtask

  // Scenario sequence
  initial begin
    applyStimulus(1'b1, 4'h0, 1'b0, 32'h0);
    test_reset();
    test_timeout();
    test_single_read();
    test_fairness();
    test_abort();
`ifdef X_USR_ACCESS_CACHE_EN
    test_cache();
`else
    test_no_cache();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
